// File: rtl/wb_rr_intercon.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves, round-robin arbitration,
// address-decode error reporting and a stalled-strobe watchdog.
module wb_rr_intercon #(
   parameter int unsigned NM      = 4,
   parameter int unsigned NS      = 4,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned SB      = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [NM*AW-1:0]       m_adr_i,
   input  logic [NM*DW-1:0]       m_dat_i,
   input  logic [NM*(DW/8)-1:0]   m_sel_i,
   input  logic [NM-1:0]          m_we_i,
   input  logic [NM-1:0]          m_cyc_i,
   input  logic [NM-1:0]          m_stb_i,
   output logic [DW-1:0]          m_dat_o,
   output logic [NM-1:0]          m_ack_o,
   output logic [NM-1:0]          m_err_o,
   output logic [AW-1:0]          s_adr_o,
   output logic [DW-1:0]          s_dat_o,
   output logic [DW/8-1:0]        s_sel_o,
   output logic                   s_we_o,
   output logic [NS-1:0]          s_cyc_o,
   output logic [NS-1:0]          s_stb_o,
   input  logic [NS*DW-1:0]       s_dat_i,
   input  logic [NS-1:0]          s_ack_i,
   output logic [NM-1:0]          gnt_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e          state_q, state_d;
   logic [NM-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]   last_q, last_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [NM-1:0]   derr_q, derr_d;

   logic [AW-1:0]   g_adr;
   logic [DW-1:0]   g_dat;
   logic [SW-1:0]   g_sel;
   logic            g_we, g_cyc, g_stb;
   logic            busy, req, miss, tout, ack_hit, tout_err;
   logic [SB-1:0]   sidx;
   logic            sel_ack;
   logic [DW-1:0]   sel_dat;
   logic            found;
   logic [IW-1:0]   win, cand;
   logic [NM-1:0]   win_oh;

   // One-hot grant lets the master mux be a plain OR reduction.
   always_comb begin
      g_adr = '0;
      g_dat = '0;
      g_sel = '0;
      g_we  = 1'b0;
      g_cyc = 1'b0;
      g_stb = 1'b0;
      for (int k = 0; k < NM; k++) begin
         if (gnt_q[k]) begin
            g_adr = g_adr | m_adr_i[k*AW +: AW];
            g_dat = g_dat | m_dat_i[k*DW +: DW];
            g_sel = g_sel | m_sel_i[k*SW +: SW];
            g_we  = g_we  | m_we_i[k];
            g_cyc = g_cyc | m_cyc_i[k];
            g_stb = g_stb | m_stb_i[k];
         end
      end
   end

   assign busy = (state_q == StBusy);
   assign req  = busy & g_cyc & g_stb;
   assign sidx = g_adr[AW-1 -: SB];
   assign miss = (32'(sidx) >= NS);

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NS; i++) begin
         if (sidx == SB'(i)) begin
            sel_ack = s_ack_i[i];
            sel_dat = s_dat_i[i*DW +: DW];
         end
      end
   end

   assign tout     = req & (wd_q == WW'(TIMEOUT - 1));
   assign ack_hit  = req & ~miss & sel_ack;
   assign tout_err = tout & ~ack_hit;

   always_comb begin
      m_ack_o = gnt_q & {NM{ack_hit}};
      m_err_o = (derr_q & ~m_ack_o) | (gnt_q & {NM{tout_err}});
      m_dat_o = (busy & ~miss) ? sel_dat : '0;
      s_adr_o = busy ? g_adr : '0;
      s_dat_o = busy ? g_dat : '0;
      s_sel_o = busy ? g_sel : '0;
      s_we_o  = busy & g_we;
      s_cyc_o = '0;
      s_stb_o = '0;
      for (int i = 0; i < NS; i++) begin
         if (busy && !miss && !tout && sidx == SB'(i)) begin
            s_cyc_o[i] = g_cyc;
            s_stb_o[i] = g_cyc & g_stb;
         end
      end
      gnt_o = gnt_q;
   end

   // Round-robin scan starting just after the most recently granted master.
   always_comb begin
      found = 1'b0;
      win   = last_q;
      cand  = last_q;
      for (int o = 1; o <= NM; o++) begin
         cand = IW'((32'(last_q) + 32'(o)) % NM);
         if (!found && m_cyc_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      for (int k = 0; k < NM; k++) begin
         win_oh[k] = (win == IW'(k));
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StBusy;
               gnt_d   = win_oh;
               last_d  = win;
            end
         end
         StBusy: begin
            if (!g_cyc) begin
               if (found) begin
                  gnt_d  = win_oh;
                  last_d = win;
               end else begin
                  state_d = StIdle;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   // Watchdog only runs while the granted master strobes without a response.
   always_comb begin
      wd_d   = (req && !ack_hit && !(|m_err_o)) ? wd_q + WW'(1) : '0;
      derr_d = gnt_q & {NM{req & miss & ~(|derr_q)}};
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         last_q  <= IW'(NM - 1);
         wd_q    <= '0;
         derr_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         derr_q  <= derr_d;
      end
   end

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Directed self-checking bench for wb_rr_intercon (4 masters, 3 slaves, TIMEOUT 8).
module tb_wb_rr_intercon;

   localparam int unsigned NM = 4;
   localparam int unsigned NS = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SB = 2;
   localparam int unsigned TO = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NM*AW-1:0]     m_adr_i;
   logic [NM*DW-1:0]     m_dat_i;
   logic [NM*(DW/8)-1:0] m_sel_i;
   logic [NM-1:0]        m_we_i, m_cyc_i, m_stb_i;
   logic [DW-1:0]        m_dat_o;
   logic [NM-1:0]        m_ack_o, m_err_o, gnt_o;
   logic [AW-1:0]        s_adr_o;
   logic [DW-1:0]        s_dat_o;
   logic [DW/8-1:0]      s_sel_o;
   logic                 s_we_o;
   logic [NS-1:0]        s_cyc_o, s_stb_o, s_ack_i, ack_man;
   logic [NS*DW-1:0]     s_dat_i;
   logic                 auto_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign s_ack_i = ack_man | (auto_ack ? s_stb_o : '0);

   wb_rr_intercon #(
      .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SB(SB), .TIMEOUT(TO)
   ) dut (
      .sys_clk(clk), .sys_rst(rst),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .gnt_o(gnt_o)
   );

   task automatic set_m(input int k, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we);
      m_adr_i[k*AW +: AW] = adr;
      m_dat_i[k*DW +: DW] = dat;
      m_sel_i[k*4 +: 4]   = 4'hF;
      m_we_i[k]           = we;
      m_cyc_i[k]          = 1'b1;
      m_stb_i[k]          = 1'b1;
   endtask

   task automatic idle_masters();
      m_cyc_i = '0;
      m_stb_i = '0;
      m_we_i  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < NM; k++) set_m(k, 32'h0000_0000, 32'hA5A5_0000 + k, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got gnt=%b ack=%b err=%b cyc=%b stb=%b required all 0",
                  gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o);
      end
      checks++;
      if ({m_dat_o, s_adr_o, s_dat_o, s_sel_o, s_we_o} !== '0) begin
         errors++;
         $display("FAIL reset_data: got mdat=%h adr=%h sdat=%h sel=%h we=%b required 0",
                  m_dat_o, s_adr_o, s_dat_o, s_sel_o, s_we_o);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt_o !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant: got %b required 0001", gnt_o);
      end
      checks++;
      if (s_stb_o !== 3'b001) begin
         errors++;
         $display("FAIL reset_first_stb: got %b required 001", s_stb_o);
      end
      idle_masters();
   endtask

   task automatic test_single_read();
      @(negedge clk);
      set_m(1, 32'h4000_0010, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (gnt_o !== 4'b0010 || s_stb_o !== 3'b010 || s_adr_o !== 32'h4000_0010) begin
         errors++;
         $display("FAIL read_fwd: got gnt=%b stb=%b adr=%h required 0010 010 40000010",
                  gnt_o, s_stb_o, s_adr_o);
      end
      checks++;
      if (m_ack_o !== 4'b0000) begin
         errors++;
         $display("FAIL read_wait1: got ack=%b required 0000", m_ack_o);
      end
      @(negedge clk);
      checks++;
      if (m_ack_o !== 4'b0000) begin
         errors++;
         $display("FAIL read_wait2: got ack=%b required 0000", m_ack_o);
      end
      @(negedge clk);
      ack_man = 3'b010;
      s_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (m_ack_o !== 4'b0010 || m_dat_o !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read_ack: got ack=%b dat=%h required 0010 deadbeef", m_ack_o, m_dat_o);
      end
      @(posedge clk);
      #1;
      ack_man = '0;
      idle_masters();
      @(negedge clk);
      checks++;
      if (m_ack_o !== 4'b0000) begin
         errors++;
         $display("FAIL read_ack_once: got ack=%b required 0000", m_ack_o);
      end
   endtask

   task automatic test_contention();
      logic [NM-1:0] exp_ack [6];
      logic [NM-1:0] seen;
      int n_ack;
      int cyc;
      exp_ack = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
      n_ack = 0;
      cyc   = 0;
      auto_ack = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NM; k++) set_m(k, 32'h0000_0020, 32'h0, 1'b0);
      m_cyc_i = 4'b1101;
      m_stb_i = 4'b1101;
      while (n_ack < 6 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (gnt_o === 4'b0000) begin
            errors++;
            $display("FAIL rr_no_idle: got gnt=%b in cycle %0d required nonzero", gnt_o, cyc);
         end
         seen = m_ack_o;
         if (seen !== 4'b0000) begin
            checks++;
            if (seen !== exp_ack[n_ack]) begin
               errors++;
               $display("FAIL rr_order: ack %0d got %b required %b", n_ack, seen,
                        exp_ack[n_ack]);
            end
            n_ack++;
         end
         @(posedge clk);
         #1;
         if (n_ack < 6) begin
            m_cyc_i = 4'b1101 & ~seen;
            m_stb_i = 4'b1101 & ~seen;
         end else begin
            idle_masters();
         end
      end
      checks++;
      if (n_ack != 6) begin
         errors++;
         $display("FAIL rr_budget: got %0d acks required 6", n_ack);
      end
      idle_masters();
      auto_ack = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_decode_miss();
      logic [NM-1:0] exp_err;
      @(negedge clk);
      set_m(0, 32'hC000_0000, 32'h0, 1'b0);
      for (int d = 1; d <= 4; d++) begin
         @(negedge clk);
         exp_err = (d == 2 || d == 4) ? 4'b0001 : 4'b0000;
         checks++;
         if (m_err_o !== exp_err || m_ack_o !== 4'b0000) begin
            errors++;
            $display("FAIL miss_err: cycle %0d got err=%b ack=%b required %b 0000", d,
                     m_err_o, m_ack_o, exp_err);
         end
         checks++;
         if (s_stb_o !== 3'b000 || s_cyc_o !== 3'b000 || gnt_o !== 4'b0001) begin
            errors++;
            $display("FAIL miss_nostb: cycle %0d got stb=%b cyc=%b gnt=%b required 000 000 0001",
                     d, s_stb_o, s_cyc_o, gnt_o);
         end
      end
      idle_masters();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [NM-1:0] exp_err;
      logic [NS-1:0] exp_stb;
      @(negedge clk);
      set_m(3, 32'h8000_0000, 32'h0, 1'b0);
      for (int k = 0; k <= int'(TO); k++) begin
         @(negedge clk);
         exp_err = (k == int'(TO) - 1) ? 4'b1000 : 4'b0000;
         exp_stb = (k == int'(TO) - 1) ? 3'b000 : 3'b100;
         checks++;
         if (m_err_o !== exp_err || s_stb_o !== exp_stb || gnt_o !== 4'b1000) begin
            errors++;
            $display("FAIL timeout: cycle %0d got err=%b stb=%b gnt=%b required %b %b 1000",
                     k, m_err_o, s_stb_o, gnt_o, exp_err, exp_stb);
         end
      end
      idle_masters();
      @(negedge clk);
      checks++;
      if (gnt_o !== 4'b0000 || m_err_o !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_release: got gnt=%b err=%b required 0000 0000", gnt_o, m_err_o);
      end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      set_m(2, 32'h0000_0004, 32'h1234_5678, 1'b1);
      @(negedge clk);
      checks++;
      if (gnt_o !== 4'b0100 || s_we_o !== 1'b1 || s_dat_o !== 32'h1234_5678 ||
          s_stb_o !== 3'b001) begin
         errors++;
         $display("FAIL mid_write: got gnt=%b we=%b dat=%h stb=%b required 0100 1 12345678 001",
                  gnt_o, s_we_o, s_dat_o, s_stb_o);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      ack_man = 3'b001;
      @(negedge clk);
      checks++;
      if (gnt_o !== 4'b0000 || s_cyc_o !== 3'b000 || s_stb_o !== 3'b000) begin
         errors++;
         $display("FAIL mid_rst_bus: got gnt=%b cyc=%b stb=%b required 0000 000 000",
                  gnt_o, s_cyc_o, s_stb_o);
      end
      checks++;
      if (m_ack_o !== 4'b0000 || m_err_o !== 4'b0000 || s_we_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_resp: got ack=%b err=%b we=%b required 0000 0000 0",
                  m_ack_o, m_err_o, s_we_o);
      end
      rst = 1'b0;
      ack_man = '0;
      idle_masters();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      m_adr_i = '0;
      m_dat_i = '0;
      m_sel_i = '0;
      idle_masters();
      ack_man = '0;
      auto_ack = 1'b0;
      s_dat_i = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      test_reset();
      test_single_read();
      test_contention();
      test_decode_miss();
      test_timeout();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
